// File: rtl/vending_pkg.sv
// Shared definitions between vending_controller and vending_dispenser:
// FSM encoding, product indices and default timing/stock parameters.
package vending_pkg;

    localparam logic [1:0] ENC_IDLE     = 2'd0;
    localparam logic [1:0] ENC_DISPENSE = 2'd1;
    localparam logic [1:0] ENC_SETTLE   = 2'd2;
    localparam logic [1:0] ENC_DONE     = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE     = ENC_IDLE,
        ST_DISPENSE = ENC_DISPENSE,
        ST_SETTLE   = ENC_SETTLE,
        ST_DONE     = ENC_DONE
    } disp_state_t;

    localparam logic PROD1 = 1'b0;
    localparam logic PROD2 = 1'b1;

    localparam int unsigned DEF_MOTOR_CYCLES  = 8;
    localparam int unsigned DEF_SETTLE_CYCLES = 2;
    localparam int unsigned DEF_CNT_W         = 4;
    localparam int unsigned DEF_STOCK_INIT    = 15;

endpackage

// File: rtl/vend_stock_counter.sv
// Per-product stock counter: reload, decrement only when non-zero, zero flag.
module vend_stock_counter #(
    parameter int unsigned CNT_W = 4,
    parameter int unsigned INIT  = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= CNT_W'(INIT);
        end else if (load) begin
            count <= CNT_W'(INIT);
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/vending_dispenser.sv
// Mechanism-side dispenser: edge-detects vend requests, runs one motor for a
// fixed time, settles, then pulses done; refuses requests when busy or empty.
module vending_dispenser
    import vending_pkg::*;
#(
    parameter int unsigned MOTOR_CYCLES  = DEF_MOTOR_CYCLES,
    parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int unsigned CNT_W         = DEF_CNT_W,
    parameter int unsigned STOCK_INIT    = DEF_STOCK_INIT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             product1,
    input  logic             product2,
    input  logic             restock,
    output logic             motor1,
    output logic             motor2,
    output logic             busy,
    output logic             done,
    output logic             reject,
    output logic             sold_out1,
    output logic             sold_out2,
    output logic [CNT_W-1:0] stock1,
    output logic [CNT_W-1:0] stock2
);

    localparam int unsigned TMR_MAX = (MOTOR_CYCLES > SETTLE_CYCLES) ? MOTOR_CYCLES : SETTLE_CYCLES;
    localparam int unsigned TMR_W   = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX);

    disp_state_t      state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             sel_q, sel_d;
    logic             product1_q, product2_q;
    logic             req1, req2;
    logic             motor1_d, motor2_d, busy_d, done_d, reject_d;
    logic             load, dec1, dec2;
    logic             zero1, zero2;

    assign req1 = product1 & ~product1_q;
    assign req2 = product2 & ~product2_q;

    // State, timer, edge detectors and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            sel_q      <= PROD1;
            product1_q <= 1'b0;
            product2_q <= 1'b0;
            motor1     <= 1'b0;
            motor2     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            reject     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            sel_q      <= sel_d;
            product1_q <= product1;
            product2_q <= product2;
            motor1     <= motor1_d;
            motor2     <= motor2_d;
            busy       <= busy_d;
            done       <= done_d;
            reject     <= reject_d;
        end
    end

    // Next-state, timer and stock control; restock beats req1 beats req2 in IDLE
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        sel_d    = sel_q;
        reject_d = 1'b0;
        load     = 1'b0;
        dec1     = 1'b0;
        dec2     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (restock) begin
                    load = 1'b1;
                end else if (req1) begin
                    if (!zero1) begin
                        state_d = ST_DISPENSE;
                        sel_d   = PROD1;
                        timer_d = TMR_W'(MOTOR_CYCLES - 1);
                        dec1    = 1'b1;
                    end else begin
                        reject_d = 1'b1;
                    end
                end else if (req2) begin
                    if (!zero2) begin
                        state_d = ST_DISPENSE;
                        sel_d   = PROD2;
                        timer_d = TMR_W'(MOTOR_CYCLES - 1);
                        dec2    = 1'b1;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            ST_DISPENSE: begin
                if (timer_q == '0) begin
                    state_d = ST_SETTLE;
                    timer_d = TMR_W'(SETTLE_CYCLES - 1);
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            ST_SETTLE: begin
                if (timer_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if ((state_q != ST_IDLE) && (req1 || req2)) begin
            reject_d = 1'b1;
        end
        motor1_d = (state_d == ST_DISPENSE) && (sel_d == PROD1);
        motor2_d = (state_d == ST_DISPENSE) && (sel_d == PROD2);
        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_d == ST_DONE);
    end

    vend_stock_counter #(.CNT_W(CNT_W), .INIT(STOCK_INIT)) u_stock1 (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .dec   (dec1),
        .count (stock1),
        .zero  (zero1)
    );

    vend_stock_counter #(.CNT_W(CNT_W), .INIT(STOCK_INIT)) u_stock2 (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .dec   (dec2),
        .count (stock2),
        .zero  (zero2)
    );

    assign sold_out1 = zero1;
    assign sold_out2 = zero2;

endmodule

// File: tb/tb_vending_dispenser.sv
// Randomized and directed bench for vending_dispenser against a vend-window model.
module tb_vending_dispenser;

    localparam int unsigned M    = 8;
    localparam int unsigned S    = 2;
    localparam int unsigned W    = 4;
    localparam int unsigned INIT = 15;

    logic         clk = 1'b0;
    logic         reset;
    logic         product1, product2, restock;
    logic         motor1, motor2, busy, done, reject;
    logic         sold_out1, sold_out2;
    logic [W-1:0] stock1, stock2;

    int checks = 0;
    int errors = 0;

    // model: a vend occupies edges vs .. vs+M+S after the accepting edge vs
    int cyc = 0;
    int vs = -1;
    int vprod = 0;
    int mstock1 = INIT;
    int mstock2 = INIT;
    logic mrej = 1'b0;
    logic p1_prev = 1'b0;
    logic p2_prev = 1'b0;
    int motor1_seen = 0;
    int motor2_seen = 0;

    always #5 clk = ~clk;

    vending_dispenser #(
        .MOTOR_CYCLES (M),
        .SETTLE_CYCLES(S),
        .CNT_W        (W),
        .STOCK_INIT   (INIT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .product1 (product1),
        .product2 (product2),
        .restock  (restock),
        .motor1   (motor1),
        .motor2   (motor2),
        .busy     (busy),
        .done     (done),
        .reject   (reject),
        .sold_out1(sold_out1),
        .sold_out2(sold_out2),
        .stock1   (stock1),
        .stock2   (stock2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        vs = -1;
        mstock1 = INIT;
        mstock2 = INIT;
        mrej = 1'b0;
        p1_prev = 1'b0;
        p2_prev = 1'b0;
    endtask

    task automatic model_edge();
        logic idle, r1, r2;
        cyc++;
        idle = !((vs >= 0) && (cyc - 1 >= vs) && (cyc - 1 <= vs + int'(M + S)));
        r1 = product1 & ~p1_prev;
        r2 = product2 & ~p2_prev;
        mrej = 1'b0;
        if (idle) begin
            if (restock) begin
                mstock1 = INIT;
                mstock2 = INIT;
            end else if (r1) begin
                if (mstock1 > 0) begin mstock1--; vs = cyc; vprod = 1; end
                else mrej = 1'b1;
            end else if (r2) begin
                if (mstock2 > 0) begin mstock2--; vs = cyc; vprod = 2; end
                else mrej = 1'b1;
            end
        end else if (r1 || r2) begin
            mrej = 1'b1;
        end
        p1_prev = product1;
        p2_prev = product2;
    endtask

    task automatic compare_all();
        logic in_vend, mon;
        in_vend = (vs >= 0) && (cyc >= vs) && (cyc <= vs + int'(M + S));
        mon = (vs >= 0) && (cyc >= vs) && (cyc < vs + int'(M));
        check("motor1", 32'(motor1), 32'(mon && vprod == 1));
        check("motor2", 32'(motor2), 32'(mon && vprod == 2));
        check("busy", 32'(busy), 32'(in_vend));
        check("done", 32'(done), 32'((vs >= 0) && (cyc == vs + int'(M + S))));
        check("reject", 32'(reject), 32'(mrej));
        check("stock1", 32'(stock1), 32'(mstock1));
        check("stock2", 32'(stock2), 32'(mstock2));
        check("sold_out1", 32'(sold_out1), 32'(mstock1 == 0));
        check("sold_out2", 32'(sold_out2), 32'(mstock2 == 0));
        if (motor1) motor1_seen++;
        if (motor2) motor2_seen++;
    endtask

    // call at a negedge: drive inputs, clock once, model then compare
    task automatic step(input logic p1, input logic p2, input logic rs);
        product1 = p1;
        product2 = p2;
        restock  = rs;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        product1 = 1'b0;
        product2 = 1'b0;
        restock  = 1'b0;
        reset    = 1'b1;
        model_reset();
        #1;
        check("rst_motor1", 32'(motor1), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        compare_all();
    endtask

    initial begin
        logic p1, p2, rs;
        reset = 1'b0;
        product1 = 1'b0;
        product2 = 1'b0;
        restock = 1'b0;
        @(negedge clk);
        do_reset();

        // 1: held level gives one 8-cycle vend
        motor1_seen = 0;
        repeat (3) step(1'b1, 1'b0, 1'b0);
        idle_n(14);
        check("t1_motor_cycles", 32'(motor1_seen), 32'd8);
        check("t1_stock1", 32'(stock1), 32'd14);

        // 2: simultaneous rise, product1 wins, no reject
        motor2_seen = 0;
        step(1'b1, 1'b1, 1'b0);
        idle_n(13);
        check("t2_motor2_never", 32'(motor2_seen), 32'd0);
        check("t2_stock2", 32'(stock2), 32'd15);

        // 3: product2 during a product1 vend is refused
        step(1'b1, 1'b0, 1'b0);
        idle_n(3);
        step(1'b0, 1'b1, 1'b0);
        check("t3_reject", 32'(reject), 32'd1);
        idle_n(10);
        check("t3_motor2_never", 32'(motor2_seen), 32'd0);
        check("t3_stock2", 32'(stock2), 32'd15);

        // 4: drain product1, then request empty, then restock
        for (int i = 0; i < 20 && mstock1 > 0; i++) begin
            step(1'b1, 1'b0, 1'b0);
            idle_n(12);
        end
        check("t4_stock1_empty", 32'(stock1), 32'd0);
        check("t4_sold_out1", 32'(sold_out1), 32'd1);
        motor1_seen = 0;
        step(1'b1, 1'b0, 1'b0);
        check("t4_reject", 32'(reject), 32'd1);
        idle_n(4);
        check("t4_no_motor", 32'(motor1_seen), 32'd0);
        step(1'b0, 1'b0, 1'b1);
        check("t4_restock", 32'(stock1), 32'd15);
        check("t4_sold_out1_clr", 32'(sold_out1), 32'd0);
        idle_n(2);

        // 5: reset on the 4th motor cycle drops outputs without a clock
        step(1'b1, 1'b0, 1'b0);
        idle_n(3);
        check("t5_motor_on", 32'(motor1), 32'd1);
        reset = 1'b1;
        model_reset();
        #1;
        check("t5_async_motor1", 32'(motor1), 32'd0);
        check("t5_async_busy", 32'(busy), 32'd0);
        check("t5_async_stock1", 32'(stock1), 32'd15);
        product1 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        motor1_seen = 0;
        step(1'b1, 1'b0, 1'b0);
        idle_n(12);
        check("t5_revend_cycles", 32'(motor1_seen), 32'd8);

        // 6: restock while busy is ignored
        step(1'b1, 1'b0, 1'b0);
        idle_n(2);
        step(1'b0, 1'b0, 1'b1);
        idle_n(10);
        check("t6_stock1", 32'(stock1), 32'd13);

        // random traffic
        p1 = 1'b0;
        p2 = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) p1 = ~p1;
            if ($urandom_range(0, 3) == 0) p2 = ~p2;
            rs = ($urandom_range(0, 39) == 0);
            step(p1, p2, rs);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
